// File: rtl/bp_pkg.sv
// Shared constants for the BTB/BHT next-PC predictor: opcodes, link registers,
// counter type and weak counter states.
package bp_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    localparam int unsigned CTR_W_DEF = 2;
    typedef logic [CTR_W_DEF-1:0] ctr_t;
    localparam ctr_t CTR_WEAK_T  = ctr_t'(2 ** (CTR_W_DEF - 1));
    localparam ctr_t CTR_WEAK_NT = ctr_t'(2 ** (CTR_W_DEF - 1) - 1);

    // x1 and x5 are the standard link registers for call/return detection
    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage with per-entry saturating direction counters.
// One combinational read port for IF, one write port that trains from EX.
module bp_btb_table #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 1024,
    parameter int unsigned CTR_W   = 2,
    localparam int unsigned IDX_W  = $clog2(ENTRIES),
    localparam int unsigned TAG_W  = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    output logic             rd_dir,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target,
    input  logic             wr_taken,
    input  logic             wr_jump
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(2 ** (CTR_W - 1) - 1);

    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [XLEN-1:0]  target [ENTRIES];
    logic [CTR_W-1:0] ctr    [ENTRIES];

    logic             wr_hit;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;

    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tag[rd_idx];
    assign rd_target = target[rd_idx];
    assign rd_dir    = ctr[rd_idx][CTR_W-1];

    // Counter training: jumps pin to max, new entries start weak, hits saturate
    always_comb begin
        ctr_cur  = ctr[wr_idx];
        wr_hit   = valid[wr_idx] && (tag[wr_idx] == wr_tag);
        ctr_next = ctr_cur;
        if (wr_jump) begin
            ctr_next = CTR_MAX;
        end else if (!wr_hit) begin
            ctr_next = wr_taken ? WEAK_T : WEAK_NT;
        end else if (wr_taken) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_next = ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= WEAK_NT;
            end
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
            ctr[wr_idx]   <= ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// IF-stage next-PC predictor (BTB + BHT) with EX-stage training and flush.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 1024,
    parameter int unsigned CTR_W       = 2,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_PC_IF,
    input  logic [31:0]     i_inst_IF,
    input  logic [XLEN-1:0] i_PC_ID,
    input  logic [XLEN-1:0] i_PC_EX,
    input  logic [XLEN-1:0] i_br_PC_EX,
    input  logic            i_branch_taken_EX,
    input  logic            i_is_br_EX,
    input  logic            i_is_jump_EX,
    input  logic            i_stall,
    output logic [XLEN-1:0] o_next_PC,
    output logic            o_flush,
    output logic            o_pred_taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [4:0]      op;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic            rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0] rd_target;
    logic            rd_dir;
    logic            btb_taken;
    logic            ex_ctl;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] expected;
    logic            ras_hit;
    logic [XLEN-1:0] ras_top;
    logic            pred_c;
    logic [XLEN-1:0] pred_target;

    assign op      = i_inst_IF[6:2];
    assign is_br   = (op == OP_BRANCH);
    assign is_jal  = (op == OP_JAL);
    assign is_jalr = (op == OP_JALR);

    bp_btb_table #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES),
        .CTR_W   (CTR_W)
    ) u_table (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .rd_idx    (i_PC_IF[IDX_W+1:2]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_dir    (rd_dir),
        .wr_en     (ex_ctl && !i_stall),
        .wr_idx    (i_PC_EX[IDX_W+1:2]),
        .wr_tag    (i_PC_EX[XLEN-1:IDX_W+2]),
        .wr_target (i_br_PC_EX),
        .wr_taken  (i_branch_taken_EX),
        .wr_jump   (i_is_jump_EX)
    );

    assign btb_taken = rd_valid && (rd_tag == i_PC_IF[XLEN-1:IDX_W+2])
                       && (is_jal || is_jalr || (is_br && rd_dir));

    // EX resolution: the ID PC must equal the true successor or IF/ID is flushed
    assign ex_ctl   = i_is_br_EX || i_is_jump_EX;
    assign pc_plus4 = i_PC_IF + XLEN'(4);
    assign expected = i_branch_taken_EX ? i_br_PC_EX : (i_PC_EX + XLEN'(4));
    assign o_flush  = i_rst_n && ex_ctl && (i_PC_ID != expected);

`ifdef BP_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_upd;
    logic             unused_bits;

    assign ras_push    = (is_jal || is_jalr) && is_link(i_inst_IF[11:7]);
    assign ras_pop     = is_jalr && is_link(i_inst_IF[19:15]) && (i_inst_IF[11:7] == REG_X0);
    assign ras_upd     = !i_stall && !o_flush;
    assign ras_top     = ras_mem[ras_ptr - PTR_W'(1)];
    assign ras_hit     = ras_pop && (ras_cnt != '0);
    assign unused_bits = ^{i_inst_IF[31:20], i_inst_IF[14:12], i_inst_IF[1:0]};

    // Circular stack: a push when full silently overwrites the oldest slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_upd) begin
            if (ras_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (ras_hit) begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (ras_upd && ras_push) ras_mem[ras_ptr] <= pc_plus4;
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_bits;

    assign ras_hit     = 1'b0;
    assign ras_top     = '0;
    assign unused_bits = ^{i_inst_IF[31:7], i_inst_IF[1:0]};
`endif

    // Next-PC select: EX correction beats RAS, RAS beats BTB, BTB beats PC+4
    always_comb begin
        pred_c      = btb_taken;
        pred_target = rd_target;
        if (ras_hit) begin
            pred_c      = 1'b1;
            pred_target = ras_top;
        end
        o_next_PC = pc_plus4;
        if (o_flush) begin
            o_next_PC = expected;
        end else if (pred_c) begin
            o_next_PC = pred_target;
        end
    end

    assign o_pred_taken = pred_c;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios plus random
// traffic against a table-of-owners reference model (RAS scenarios under BP_RAS_EN).
module tb_branch_predictor_bht;

    localparam int N      = 1024;
    localparam int IDX_W  = 10;
    localparam int CMAX   = 3;
    localparam int WTAKEN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_if = '0, inst_if = '0, pc_id = '0, pc_ex = '0, br_pc = '0;
    logic        taken = 1'b0, is_br = 1'b0, is_jump = 1'b0, stall = 1'b0;
    logic [31:0] next_pc;
    logic        flush, pred;

    int checks = 0;
    int errors = 0;

    bit          m_valid [N];
    logic [31:0] m_owner [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_PC_IF           (pc_if),
        .i_inst_IF         (inst_if),
        .i_PC_ID           (pc_id),
        .i_PC_EX           (pc_ex),
        .i_br_PC_EX        (br_pc),
        .i_branch_taken_EX (taken),
        .i_is_br_EX        (is_br),
        .i_is_jump_EX      (is_jump),
        .i_stall           (stall),
        .o_next_PC         (next_pc),
        .o_flush           (flush),
        .o_pred_taken      (pred)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // kind: 0 other, 1 branch, 2 jal, 3 jalr
    function automatic logic [31:0] mk_inst(input int kind, input logic [4:0] rd, input logic [4:0] rs1);
        logic [6:0] opc;
        case (kind)
            1:       opc = 7'b1100011;
            2:       opc = 7'b1101111;
            3:       opc = 7'b1100111;
            default: opc = 7'b0010011;
        endcase
        return {12'h000, rs1, 3'b000, rd, opc};
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_owner[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    // Drive one cycle, check combinational outputs against the model, then train the model
    task automatic step(input logic [31:0] f_pc, input logic [31:0] f_inst, input logic [31:0] d_pc,
                        input logic [31:0] e_pc, input logic [31:0] e_tgt, input logic e_tk,
                        input logic e_br, input logic e_j, input logic stl, input string tag);
        logic [4:0]  op;
        logic [31:0] exp_pc, nxt;
        bit          ptk, fl, hit;
        int          i;
        @(negedge clk);
        pc_if = f_pc; inst_if = f_inst; pc_id = d_pc; pc_ex = e_pc; br_pc = e_tgt;
        taken = e_tk; is_br = e_br; is_jump = e_j; stall = stl;
        #1;
        op     = f_inst[6:2];
        i      = idx_of(f_pc);
        ptk    = model_hit(f_pc) && (op == 5'b11011 || op == 5'b11001 ||
                                     (op == 5'b11000 && m_ctr[i] >= WTAKEN));
        exp_pc = e_tk ? e_tgt : e_pc + 32'd4;
        fl     = (e_br || e_j) && (d_pc != exp_pc);
        nxt    = fl ? exp_pc : (ptk ? m_tgt[i] : f_pc + 32'd4);
        check32({tag, " next_pc"}, next_pc, nxt);
        check1({tag, " pred"}, pred, ptk);
        check1({tag, " flush"}, flush, fl);
        if ((e_br || e_j) && !stl) begin
            i   = idx_of(e_pc);
            hit = model_hit(e_pc);
            if (e_j)       m_ctr[i] = CMAX;
            else if (!hit) m_ctr[i] = e_tk ? WTAKEN : WTAKEN - 1;
            else if (e_tk) m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
            else           m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            m_valid[i] = 1'b1;
            m_owner[i] = e_pc;
            m_tgt[i]   = e_tgt;
        end
    endtask

    task automatic fetch(input logic [31:0] f_pc, input logic [31:0] f_inst);
        step(f_pc, f_inst, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "fetch");
    endtask

`ifdef BP_RAS_EN
    task automatic ras_fetch(input logic [31:0] f_pc, input logic [31:0] f_inst);
        @(negedge clk);
        pc_if = f_pc; inst_if = f_inst; pc_id = '0; pc_ex = '0; br_pc = '0;
        taken = 1'b0; is_br = 1'b0; is_jump = 1'b0; stall = 1'b0;
        #1;
    endtask
`endif

    logic [31:0] br_i, jal_i;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = WTAKEN - 1;
            m_owner[i] = '0;
            m_tgt[i]   = '0;
        end
        br_i  = mk_inst(1, 5'd0, 5'd0);
        jal_i = mk_inst(2, 5'd0, 5'd0);

        // Reset: flush held low even with a mispredicting EX branch
        pc_if = 32'h100; inst_if = br_i; pc_id = 32'h104; pc_ex = 32'h100;
        br_pc = 32'h40; taken = 1'b1; is_br = 1'b1;
        #2;
        check1("reset flush", flush, 1'b0);
        check32("reset next_pc", next_pc, 32'h104);
        @(negedge clk);
        is_br = 1'b0; taken = 1'b0;
        rst_n = 1'b1;

        fetch(32'h100, br_i);
        check32("empty next_pc", next_pc, 32'h104);
        check1("empty pred", pred, 1'b0);

        // Taken branch trains the entry and redirects via flush
        step(32'h100, br_i, 32'h104, 32'h100, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, "train");
        check32("train flush target", next_pc, 32'h40);
        check1("train flush", flush, 1'b1);
        fetch(32'h100, br_i);
        check32("trained next_pc", next_pc, 32'h40);

        // Not-taken training down to saturation at zero
        for (int k = 0; k < 3; k++)
            step(32'h100, br_i, 32'h104, 32'h100, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, "nt");
        fetch(32'h100, br_i);
        check32("nt predicts fallthrough", next_pc, 32'h104);
        step(32'h100, br_i, 32'h44, 32'h100, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, "sat");
        fetch(32'h100, br_i);
        check32("saturated at zero", next_pc, 32'h104);

        // Alias one table span above: tag miss
        fetch(32'h100 + 32'(4 * N), br_i);
        check32("alias next_pc", next_pc, 32'h1104);

        // Stall: flush still visible, no training
        step(32'h300, br_i, 32'h304, 32'h300, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, "stall");
        check1("stall flush", flush, 1'b1);
        fetch(32'h300, br_i);
        check32("stall no write", next_pc, 32'h304);

        // Jump trained then predicted on fetch
        step(32'h180, jal_i, 32'h184, 32'h180, 32'h900, 1'b1, 1'b0, 1'b1, 1'b0, "jump");
        fetch(32'h180, jal_i);
        check32("jump predicted", next_pc, 32'h900);

        // Random traffic over a small aliasing pool
        for (int n = 0; n < 400; n++) begin
            logic [31:0] fp, ep, tg, dp, ins;
            logic tk, eb, ej, st;
            int ek;
            fp  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
            ep  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
            ins = mk_inst(int'($urandom_range(0, 3)), 5'd0, 5'd2);
            tg  = $urandom & 32'h0000_fffc;
            ek  = int'($urandom_range(0, 3));
            eb  = (ek == 1 || ek == 3);
            ej  = (ek == 2);
            tk  = ej ? 1'b1 : 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 4) == 0);
            dp  = ($urandom_range(0, 1) == 1) ? (tk ? tg : ep + 32'd4) : ($urandom & 32'h0000_fffc);
            step(fp, ins, dp, ep, tg, tk, eb, ej, st, "rand");
        end

`ifdef BP_RAS_EN
        // Call then return
        ras_fetch(32'h200, mk_inst(2, 5'd1, 5'd0));
        ras_fetch(32'h500, mk_inst(3, 5'd0, 5'd1));
        check32("ras return", next_pc, 32'h204);
        check1("ras pred", pred, 1'b1);
        // Nine nested calls into an eight-deep stack
        for (int k = 0; k < 9; k++)
            ras_fetch(32'h8400 + 32'(k * 64), mk_inst(2, 5'd1, 5'd0));
        for (int k = 8; k >= 1; k--) begin
            ras_fetch(32'h500, mk_inst(3, 5'd0, 5'd1));
            check32("ras nested", next_pc, 32'h8404 + 32'(k * 64));
        end
        ras_fetch(32'h500, mk_inst(3, 5'd0, 5'd1));
        check32("ras oldest lost", next_pc, 32'h504);
        check1("ras empty pred", pred, 1'b0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
